// File: rtl/alu_sequencer.sv
// Program sequencer: fetches words from a synchronous instruction ROM,
// drives an external combinational ALU and retires results into an accumulator.
module alu_sequencer #(
  parameter int unsigned BITS = 8,
  parameter int unsigned OP   = 4,
  parameter int unsigned SIZE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              rom_en,
  output logic [SIZE-1:0]   rom_addr,
  input  logic [OP+BITS-1:0] rom_data,
  output logic [OP-1:0]     alu_op,
  output logic [BITS-1:0]   alu_a,
  output logic [BITS-1:0]   alu_b,
  input  logic [BITS-1:0]   alu_result,
  output logic [BITS-1:0]   acc,
  output logic [BITS-1:0]   out_data,
  output logic              out_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [OP-1:0]   opcode;
    logic [BITS-1:0] imm;
  } ir_t;

  localparam logic [OP-1:0]   OPC_DIV  = OP'(3);
  localparam logic [OP-1:0]   OPC_MOD  = OP'(4);
  localparam logic [OP-1:0]   OPC_LOAD = OP'(8);
  localparam logic [OP-1:0]   OPC_OUT  = OP'(9);
  localparam logic [OP-1:0]   OPC_HALT = OP'(15);
  localparam logic [SIZE-1:0] PC_LAST  = '1;

  state_t          state;
  ir_t             ir;
  logic [SIZE-1:0] pc;

  logic is_alu_c;
  logic div_zero_c;
  logic last_c;

  // Instruction-register decode used during EXEC.
  assign is_alu_c   = (ir.opcode < OPC_LOAD);
  assign div_zero_c = ((ir.opcode == OPC_DIV) || (ir.opcode == OPC_MOD)) &&
                      (ir.imm == '0);
  assign last_c     = (ir.opcode == OPC_HALT) || (pc == PC_LAST);

  // ALU operands come straight from architectural registers.
  assign rom_addr = pc;
  assign alu_op   = ir.opcode;
  assign alu_a    = acc;
  assign alu_b    = ir.imm;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      pc        <= '0;
      ir        <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      rom_en    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      rom_en    <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            pc     <= '0;
            acc    <= '0;
            err    <= 1'b0;
            done   <= 1'b0;
            busy   <= 1'b1;
            rom_en <= 1'b1;
            state  <= S_FETCH;
          end
        end
        S_FETCH: begin
          state <= S_DECODE;
        end
        S_DECODE: begin
          ir    <= ir_t'(rom_data);
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (div_zero_c) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            if (is_alu_c) begin
              acc <= alu_result;
            end else if (ir.opcode == OPC_LOAD) begin
              acc <= ir.imm;
            end else if (ir.opcode == OPC_OUT) begin
              out_data  <= acc;
              out_valid <= 1'b1;
            end
            // The last ROM word ends the program instead of wrapping the PC.
            if (last_c) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              pc     <= pc + SIZE'(1);
              rom_en <= 1'b1;
              state  <= S_FETCH;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
